// File: rtl/ifu_fetch_queue_if.sv
// Fetch-stage bundle: imem request/response, decode handoff and backend redirect.
// master = fetch queue side; slave = memory/decode/backend side.
interface ifu_fetch_queue_if #(
  parameter int PC_WD   = 32,
  parameter int INST_WD = 32,
  parameter int CNT_WD  = 3
);
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [PC_WD-1:0]   imem_req_addr;
  logic               imem_resp_valid;
  logic [INST_WD-1:0] imem_resp_data;
  logic               fs_to_ds_valid;
  logic               ds_allowin;
  logic [PC_WD-1:0]   fs_pc;
  logic [INST_WD-1:0] fs_inst;
  logic               fs_pred_taken;
  logic [PC_WD-1:0]   fs_pred_target;
  logic               flush;
  logic [PC_WD-1:0]   flush_pc;
  logic [CNT_WD-1:0]  queue_count;

  modport master (
    output imem_req_valid, imem_req_addr, fs_to_ds_valid, fs_pc, fs_inst,
           fs_pred_taken, fs_pred_target, queue_count,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, ds_allowin, flush, flush_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, fs_to_ds_valid, fs_pc, fs_inst,
           fs_pred_taken, fs_pred_target, queue_count,
    output imem_req_ready, imem_resp_valid, imem_resp_data, ds_allowin, flush, flush_pc
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Fetch queue with static prediction; response visible at the head the cycle after it arrives.
// Requests are credit-limited so queue + live in-flight never exceeds DEPTH; decode stalls just hold the head.
module ifu_fetch_queue #(
  parameter int               PC_WD           = 32,
  parameter int               INST_WD         = 32,
  parameter int               DEPTH           = 4,
  parameter int               MAX_OUTSTANDING = 2,
  parameter logic [PC_WD-1:0] RESET_PC        = PC_WD'(32'h8000_0000),
  parameter bit               BTFN_EN         = 1'b1
) (
  input logic               clk,
  input logic               reset,
  ifu_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int UW = CW + OW + 1;

  typedef struct packed {
    logic [PC_WD-1:0]   pc;
    logic [INST_WD-1:0] inst;
    logic               taken;
    logic [PC_WD-1:0]   target;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  entry_t             new_entry;
  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count;
  logic [OW-1:0]      outstanding, drop_cnt;
  logic [PC_WD-1:0]   fetch_pc, resp_pc, redirect_pc;
  logic [UW-1:0]      credit_used;
  logic               resp_valid, drop, enq, deq, fire, req_valid, redirect, has_head;
  logic [INST_WD-1:0] inst;
  logic [PC_WD-1:0]   imm_j, imm_b, pred_target;
  logic               is_jal, is_br, br_taken, pred_taken;

  assign resp_valid = bus.imem_resp_valid;
  assign inst       = bus.imem_resp_data;

  // Immediates decoded straight from the RV32 encoding, sign-extended to PC width.
  assign imm_j    = {{(PC_WD-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_b    = {{(PC_WD-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign is_jal   = inst[6:0] == 7'b1101111;
  assign is_br    = (inst[6:0] == 7'b1100011) && (inst[14:12] != 3'b010) && (inst[14:12] != 3'b011);
  assign br_taken = BTFN_EN && is_br && inst[31];

  assign pred_taken  = is_jal || br_taken;
  assign pred_target = is_jal   ? resp_pc + imm_j :
                       br_taken ? resp_pc + imm_b : resp_pc + PC_WD'(4);

  assign drop        = resp_valid && (drop_cnt != '0);
  assign enq         = resp_valid && (drop_cnt == '0) && !bus.flush;
  assign redirect    = bus.flush || (enq && pred_taken);
  assign redirect_pc = bus.flush ? bus.flush_pc : pred_target;

  // Responses already marked for drop hold no queue slot.
  assign credit_used = UW'(count) + UW'(outstanding) - UW'(drop_cnt);
  assign req_valid   = reset && !redirect && (outstanding < OW'(MAX_OUTSTANDING)) &&
                       (credit_used < UW'(DEPTH));
  assign fire        = req_valid && bus.imem_req_ready;

  assign has_head = count != '0;
  assign deq      = bus.fs_to_ds_valid && bus.ds_allowin;
  assign head     = mem[rd_ptr];

  assign new_entry = '{pc: resp_pc, inst: inst, taken: pred_taken, target: pred_target};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding + OW'(fire) - OW'(resp_valid);
      // Everything still in flight at a redirect belongs to the abandoned path.
      if (redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        drop_cnt <= outstanding - OW'(resp_valid);
      end else begin
        if (fire) fetch_pc <= fetch_pc + PC_WD'(4);
        if (enq)  resp_pc  <= resp_pc + PC_WD'(4);
        if (drop) drop_cnt <= drop_cnt - OW'(1);
      end
      if (bus.flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + AW'(1);
        if (deq) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= new_entry;
  end

  no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(enq && !deq && (count == CW'(DEPTH))));

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.fs_to_ds_valid = has_head && !bus.flush;
  assign bus.fs_pc          = has_head ? head.pc     : '0;
  assign bus.fs_inst        = has_head ? head.inst   : '0;
  assign bus.fs_pred_taken  = has_head && head.taken;
  assign bus.fs_pred_target = has_head ? head.target : '0;
  assign bus.queue_count    = count;
endmodule
